opsum_collector: RTL

- Sits directly downstream of one PE wrapper: consumes its {enable,data} opsum stream through the opsum_ready handshake.
- Buffers psums in a small FIFO and packs PACK_NUM psums into one GLB word.
- Writes packed words to the global buffer at consecutive addresses from a configured base, then pulses done.
- One instance per PE column output (GON tail).

---
 rtl/opsum_collector.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/opsum_collector.sv
// Opsum collector: buffers a PE opsum stream, packs PACK_NUM psums per word and writes
// them to the GLB from a configured base address. Define OPSUM_RELU_EN to clamp negatives to 0.
module opsum_collector #(
   parameter int PSUM_DATA_SIZE = 8,
   parameter int OPSUM_NUM      = 1,
   parameter int PACK_NUM       = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int ADDR_BIT       = 16,
   parameter int LEN_BIT        = 12
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 enable,
   input  logic [OPSUM_NUM*PSUM_DATA_SIZE:0]    opsum_in,
   output logic                                 opsum_ready,
   input  logic                                 set_info,
   input  logic [ADDR_BIT-1:0]                  cfg_base_addr,
   input  logic [LEN_BIT-1:0]                   cfg_len,
   output logic [PACK_NUM*PSUM_DATA_SIZE-1:0]   glb_wdata,
   output logic [ADDR_BIT-1:0]                  glb_waddr,
   output logic                                 glb_wvalid,
   input  logic                                 glb_wready,
   output logic                                 busy,
   output logic                                 done
);
   localparam int IN_W   = OPSUM_NUM * PSUM_DATA_SIZE;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
   localparam int WORD_W = PACK_NUM * PSUM_DATA_SIZE;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                    state_q, state_d;
   logic [LEN_BIT-1:0]        len_q, len_d;
   logic [LEN_BIT-1:0]        recv_cnt_q, recv_cnt_d;
   logic [LEN_BIT-1:0]        pop_cnt_q, pop_cnt_d;
   logic [PTR_W:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]            rd_ptr_q, rd_ptr_d;
   logic [LANE_W-1:0]         lane_idx_q, lane_idx_d;
   logic [WORD_W-1:0]         pack_q, pack_d;
   logic [WORD_W-1:0]         wdata_q, wdata_d;
   logic [ADDR_BIT-1:0]       waddr_q, waddr_d;
   logic                      wvalid_q, wvalid_d;
   logic [PSUM_DATA_SIZE-1:0] fifo_mem_q [FIFO_DEPTH];

   logic                      fifo_full, fifo_empty, push, pop, last_pop, fill_done, wr_hs;
   logic [PSUM_DATA_SIZE-1:0] pop_data;
   logic [WORD_W-1:0]         pack_next;

   function automatic logic [PSUM_DATA_SIZE-1:0] clip_psum(input logic [PSUM_DATA_SIZE-1:0] v);
`ifdef OPSUM_RELU_EN
      clip_psum = v[PSUM_DATA_SIZE-1] ? '0 : v;
`else
      clip_psum = v;
`endif
   endfunction

   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign opsum_ready = enable && (state_q == RUN) && !fifo_full && (recv_cnt_q < len_q);
   assign push        = opsum_in[IN_W] && opsum_ready;
   // A pending GLB word blocks popping, so the FIFO soaks up write backpressure.
   assign pop         = !fifo_empty && enable && !wvalid_q;
   assign pop_data    = clip_psum(fifo_mem_q[rd_ptr_q[PTR_W-1:0]]);
   assign last_pop    = ((pop_cnt_q + 1'b1) == len_q);
   assign fill_done   = pop && ((lane_idx_q == LANE_W'(PACK_NUM - 1)) || last_pop);
   assign wr_hs       = wvalid_q && glb_wready;

   assign glb_wdata  = wdata_q;
   assign glb_waddr  = waddr_q;
   assign glb_wvalid = wvalid_q;
   assign busy       = (state_q == RUN) || (state_q == FLUSH);
   assign done       = (state_q == DONE);

   always_comb begin
      pack_next = pack_q;
      pack_next[lane_idx_q*PSUM_DATA_SIZE +: PSUM_DATA_SIZE] = pop_data;
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      recv_cnt_d = recv_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      lane_idx_d = lane_idx_q;
      pack_d     = pack_q;
      wdata_d    = wdata_q;
      waddr_d    = waddr_q;
      wvalid_d   = wvalid_q;

      if (push) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         recv_cnt_d = recv_cnt_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pop_cnt_d = pop_cnt_q + 1'b1;
         if (fill_done) begin
            wdata_d    = pack_next;
            wvalid_d   = 1'b1;
            pack_d     = '0;
            lane_idx_d = '0;
         end else begin
            pack_d     = pack_next;
            lane_idx_d = lane_idx_q + 1'b1;
         end
      end
      if (wr_hs) begin
         wvalid_d = 1'b0;
         waddr_d  = waddr_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (set_info && (cfg_len != '0)) begin
               len_d      = cfg_len;
               waddr_d    = cfg_base_addr;
               recv_cnt_d = '0;
               pop_cnt_d  = '0;
               lane_idx_d = '0;
               pack_d     = '0;
               state_d    = RUN;
            end
         end
         RUN:   if (enable && (recv_cnt_q == len_q)) state_d = FLUSH;
         FLUSH: if (wr_hs && (pop_cnt_q == len_q)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         recv_cnt_q <= '0;
         pop_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         lane_idx_q <= '0;
         pack_q     <= '0;
         wdata_q    <= '0;
         waddr_q    <= '0;
         wvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         recv_cnt_q <= recv_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         lane_idx_q <= lane_idx_d;
         pack_q     <= pack_d;
         wdata_q    <= wdata_d;
         waddr_q    <= waddr_d;
         wvalid_q   <= wvalid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= opsum_in[IN_W-1:0];
   end
endmodule
